// File: rtl/onchip_mem_stream_master.sv
`default_nettype none
// ============================================================================
// Module   : onchip_mem_stream_master
// Purpose  : Avalon-MM master for a single-port on-chip RAM (1-cycle read
//            latency, no waitrequest). Executes block commands:
//            READ  - streams cmd_len words from RAM to the dst stream
//            WRITE - stores cmd_len words from the src stream into RAM
// Ports    : clk/reset             - clock, synchronous active-high reset
//            cmd_*                 - command handshake, base, length
//            src_*                 - write data stream (valid/ready)
//            dst_*                 - read data stream (valid/ready, show-ahead)
//            busy/done/err         - status, done/err are 1-cycle pulses
//            avm_*                 - RAM master interface
// Revision : 1.0 - initial release
// ============================================================================
module onchip_mem_stream_master #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_base,
    input  logic [ADDR_W:0]     cmd_len,
    input  logic [DATA_W-1:0]   src_data,
    input  logic                src_valid,
    output logic                src_ready,
    output logic [DATA_W-1:0]   dst_data,
    output logic                dst_valid,
    input  logic                dst_ready,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ADDR_W-1:0]   avm_address,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic                avm_chipselect,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic                avm_clken,
    input  logic [DATA_W-1:0]   avm_readdata
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [2:0] c_S_IDLE     = 3'd0;
    localparam logic [2:0] c_S_RD_ISSUE = 3'd1;
    localparam logic [2:0] c_S_RD_DRAIN = 3'd2;
    localparam logic [2:0] c_S_WR       = 3'd3;
    localparam logic [2:0] c_S_FIN      = 3'd4;

    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0]  c_ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]    c_REM_ONE  = (ADDR_W + 1)'(1);

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W:0]    r_remaining;
    logic               r_outstanding;
    logic               r_illegal;
    logic [DATA_W-1:0]  r_fifo [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_len_ok;
    logic w_accept;
    logic w_issue;
    logic w_wr_beat;
    logic w_push;
    logic w_pop;

    // Legal lengths are 1..2^ADDR_W: nonzero and, if the MSB is set, nothing below it.
    assign w_len_ok  = (cmd_len != '0) && (!cmd_len[ADDR_W] || (cmd_len[ADDR_W-1:0] == '0));
    assign w_accept  = (r_state == c_S_IDLE) && cmd_valid && w_len_ok;
    // Credit check: words buffered plus the read in flight must leave a free slot.
    assign w_issue   = (r_state == c_S_RD_ISSUE) && (r_remaining != '0) &&
                       ((r_count + c_CNT_W'(r_outstanding)) < c_DEPTH);
    assign w_wr_beat = (r_state == c_S_WR) && src_valid;
    assign w_push    = r_outstanding;
    assign w_pop     = (r_count != '0) && dst_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept) begin
                    w_next = cmd_write ? c_S_WR : c_S_RD_ISSUE;
                end
            end
            c_S_RD_ISSUE: begin
                if (w_issue && (r_remaining == c_REM_ONE)) begin
                    w_next = c_S_RD_DRAIN;
                end
            end
            c_S_RD_DRAIN: begin
                if (!r_outstanding && (r_count == '0)) begin
                    w_next = c_S_FIN;
                end
            end
            c_S_WR: begin
                if (w_wr_beat && (r_remaining == c_REM_ONE)) begin
                    w_next = c_S_FIN;
                end
            end
            c_S_FIN:  w_next = c_S_IDLE;
            default:  w_next = c_S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        cmd_ready      = (r_state == c_S_IDLE);
        busy           = (r_state != c_S_IDLE);
        done           = (r_state == c_S_FIN) || r_illegal;
        err            = r_illegal;
        src_ready      = (r_state == c_S_WR);
        avm_chipselect = w_issue || w_wr_beat;
        avm_write      = w_wr_beat;
        avm_address    = r_addr;
        avm_writedata  = w_wr_beat ? src_data : '0;
        avm_byteenable = '1;
        avm_clken      = 1'b1;
    end

    assign dst_valid = (r_count != '0);
    assign dst_data  = (r_count != '0) ? r_fifo[r_rptr] : '0;

    // ---------------- Address / length / read-return bookkeeping ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr        <= '0;
            r_remaining   <= '0;
            r_outstanding <= 1'b0;
            r_illegal     <= 1'b0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
        end else begin
            r_illegal     <= (r_state == c_S_IDLE) && cmd_valid && !w_len_ok;
            // At most one read is ever in flight; its data lands next cycle.
            r_outstanding <= w_issue;
            if (w_accept) begin
                r_addr      <= cmd_base;
                r_remaining <= cmd_len;
            end else if (w_issue || w_wr_beat) begin
                r_addr      <= r_addr + c_ADDR_ONE;
                r_remaining <= r_remaining - c_REM_ONE;
            end
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Buffer storage needs no reset; occupancy is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= avm_readdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_stream_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_onchip_mem_stream_master
// Purpose  : Self-checking bench: RAM slave stub, reference memory model,
//            scoreboard queues for read words and RAM writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_onchip_mem_stream_master;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_base;
    logic [8:0]  cmd_len;
    logic [31:0] src_data;
    logic        src_valid;
    logic        src_ready;
    logic [31:0] dst_data;
    logic        dst_valid;
    logic        dst_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  avm_address;
    logic [3:0]  avm_byteenable;
    logic        avm_chipselect;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_clken;
    logic [31:0] avm_readdata;

    onchip_mem_stream_master #(.ADDR_W(8), .DATA_W(32), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_base(cmd_base), .cmd_len(cmd_len),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .dst_data(dst_data), .dst_valid(dst_valid), .dst_ready(dst_ready),
        .busy(busy), .done(done), .err(err),
        .avm_address(avm_address), .avm_byteenable(avm_byteenable),
        .avm_chipselect(avm_chipselect), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_clken(avm_clken),
        .avm_readdata(avm_readdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM slave stub: 256 x 32, fixed 1-cycle read latency.
    logic [31:0] ram [256];
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'(i * 3);
        avm_readdata = '0;
        forever begin
            @(posedge clk);
            if (avm_chipselect && avm_clken) begin
                if (avm_write) ram[avm_address] <= avm_writedata;
                else           avm_readdata     <= ram[avm_address];
            end
        end
    end

    // Reference model and scoreboards
    logic [31:0] ref_mem [256];
    logic [31:0] exp_rd [$];
    logic [7:0]  exp_wa [$];
    logic [31:0] exp_wd [$];

    int n_vec  = 0;
    int n_fail = 0;
    int cyc = 0, done_cnt = 0, err_cnt = 0, cs_cnt = 0;
    int issued = 0, popped = 0, last_pop = 0;
    bit first_word = 1'b0, chk_consec = 1'b0;
    int ready_mode = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // dst_ready driver: 0 = always ready, 1 = toggle with a 10-cycle stall, 2 = random
    initial begin
        int tcnt, pmode;
        tcnt = 0; pmode = -1;
        dst_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (ready_mode != pmode) tcnt = 0;
            pmode = ready_mode;
            case (ready_mode)
                1:       dst_ready = (tcnt % 2 == 0) && !(tcnt >= 6 && tcnt < 16);
                2:       dst_ready = ($urandom_range(0, 3) != 0);
                default: dst_ready = 1'b1;
            endcase
            tcnt++;
        end
    end

    // Monitor: compares every DUT output transfer against the scoreboards.
    initial begin
        logic [31:0] e;
        logic [7:0]  ea;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                issued = 0;
                popped = 0;
            end else begin
                if (dst_valid && dst_ready) begin
                    if (exp_rd.size() == 0) begin
                        check("dst_unexpected_word", 1, 0);
                    end else begin
                        e = exp_rd.pop_front();
                        check("dst_data", dst_data, e);
                    end
                    if (chk_consec) begin
                        if (!first_word) check("dst_gap", 64'(cyc - last_pop), 1);
                        first_word = 1'b0;
                        last_pop = cyc;
                    end
                    popped++;
                end
                if (avm_chipselect) begin
                    cs_cnt++;
                    check("byteenable", avm_byteenable, 4'hF);
                    if (avm_write) begin
                        if (exp_wa.size() == 0) begin
                            check("unexpected_write", 1, 0);
                        end else begin
                            ea = exp_wa.pop_front();
                            e  = exp_wd.pop_front();
                            check("wr_addr", avm_address, ea);
                            check("wr_data", avm_writedata, e);
                        end
                    end else begin
                        issued++;
                        check("read_credit", 64'(issued - popped <= 4), 1);
                    end
                end
                if (done) done_cnt++;
                if (err)  err_cnt++;
            end
        end
    end

    task automatic issue_cmd(input logic wr, input logic [7:0] base, input logic [8:0] len);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_base = base; cmd_len = len;
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input logic exp_err);
        int n;
        for (n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (done) break;
        end
        if (n == 3000) check("done_timeout", 0, 1);
        else           check("err_with_done", err, exp_err);
    endtask

    task automatic run_read(input logic [7:0] base, input int len, input int mode, input bit consec);
        int d0, e0;
        for (int i = 0; i < len; i++) exp_rd.push_back(ref_mem[8'(base + i)]);
        ready_mode = mode; first_word = 1'b1; chk_consec = consec;
        d0 = done_cnt; e0 = err_cnt;
        issue_cmd(1'b0, base, 9'(len));
        wait_done(1'b0);
        repeat (2) @(negedge clk);
        check("rd_done_once", 64'(done_cnt - d0), 1);
        check("rd_no_err", 64'(err_cnt - e0), 0);
        check("rd_all_delivered", 64'(exp_rd.size()), 0);
        chk_consec = 1'b0; ready_mode = 0;
    endtask

    // dmode 0: data 0xA0+i; 1: random. plen 0: random valid, else pattern bits.
    task automatic run_write(input logic [7:0] base, input int len, input int dmode,
                             input logic [31:0] pat, input int plen);
        logic [31:0] wd [$];
        int d0, c0, i, c;
        for (int k = 0; k < len; k++) begin
            wd.push_back(dmode == 0 ? 32'hA0 + 32'(k) : $urandom);
            exp_wa.push_back(8'(base + k));
            exp_wd.push_back(wd[k]);
            ref_mem[8'(base + k)] = wd[k];
        end
        d0 = done_cnt; c0 = cs_cnt;
        issue_cmd(1'b1, base, 9'(len));
        i = 0; c = 0;
        while (i < len && c < 2000) begin
            src_valid = (plen == 0) ? ($urandom_range(0, 2) != 0) : pat[c % plen];
            src_data  = wd[i];
            @(negedge clk);
            if (src_valid && src_ready) i++;
            c++;
            @(posedge clk); #1;
        end
        src_valid = 1'b0;
        if (c == 2000) check("wr_stream_timeout", 0, 1);
        wait_done(1'b0);
        repeat (2) @(negedge clk);
        check("wr_done_once", 64'(done_cnt - d0), 1);
        check("wr_access_count", 64'(cs_cnt - c0), 64'(len));
        check("wr_all_seen", 64'(exp_wa.size()), 0);
    endtask

    task automatic run_illegal(input logic [8:0] len);
        int d0, e0, c0;
        d0 = done_cnt; e0 = err_cnt; c0 = cs_cnt;
        issue_cmd(1'b0, 8'h20, len);
        wait_done(1'b1);
        check("illegal_cmd_ready", cmd_ready, 1);
        check("illegal_not_busy", busy, 0);
        repeat (2) @(negedge clk);
        check("illegal_done_once", 64'(done_cnt - d0), 1);
        check("illegal_err_once", 64'(err_cnt - e0), 1);
        check("illegal_no_access", 64'(cs_cnt - c0), 0);
    endtask

    initial begin
        int p0, n, d0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i * 3);
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_base = '0; cmd_len = '0;
        src_valid = 1'b0; src_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_src_ready", src_ready, 0);
        check("rst_dst_valid", dst_valid, 0);
        check("rst_cs", avm_chipselect, 0);
        check("rst_write", avm_write, 0);
        check("rst_addr", avm_address, 0);
        check("rst_wdata", avm_writedata, 0);
        check("rst_dst_data", dst_data, 0);
        check("rst_clken", avm_clken, 1);
        @(posedge clk); #1 reset = 1'b0;

        run_read(8'h10, 8, 0, 1'b1);
        run_write(8'hFC, 6, 0, 32'h1, 1);
        run_read(8'hFC, 6, 2, 1'b0);
        run_read(8'h30, 16, 1, 1'b0);
        run_illegal(9'd0);
        run_illegal(9'd257);
        run_write(8'h50, 4, 1, 32'b1011001, 7);
        run_read(8'h4E, 8, 0, 1'b0);

        // Reset in the middle of a long read
        for (int i = 0; i < 32; i++) exp_rd.push_back(ref_mem[8'(8'h80 + i)]);
        ready_mode = 0;
        p0 = popped;
        issue_cmd(1'b0, 8'h80, 9'd32);
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (popped - p0 >= 5) break;
        end
        if (n == 200) check("mid_read_timeout", 0, 1);
        d0 = done_cnt;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        check("mrst_dst_valid", dst_valid, 0);
        check("mrst_busy", busy, 0);
        check("mrst_cmd_ready", cmd_ready, 1);
        check("mrst_cs", avm_chipselect, 0);
        reset = 1'b0;
        exp_rd.delete();
        repeat (3) @(negedge clk);
        check("mrst_no_done", 64'(done_cnt - d0), 0);
        run_read(8'h40, 2, 0, 1'b0);

        // Randomized mix
        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 1) == 1)
                run_write(8'($urandom), int'($urandom_range(1, 20)), 1, 32'h0, 0);
            else
                run_read(8'($urandom), int'($urandom_range(1, 20)), 2, 1'b0);
        end
        run_read(8'($urandom), 256, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
